// File: rtl/RS5_pkg.sv
// Shared types and helpers for the RS5 memory-port arbitration logic.
package RS5_pkg;

    localparam int unsigned MEM_DATA_W = 32;
    localparam int unsigned MEM_BE_W   = 4;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    // Requester-side view of one transfer, as presented by the core or DMA glue.
    typedef struct packed {
        logic                  en;
        logic [MEM_BE_W-1:0]   we;
        logic [31:0]           addr;
        logic [MEM_DATA_W-1:0] data;
        logic                  lock;
    } mem_req_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: picks the first asserted request at or after ptr_i, cyclically.
module rr_pick #(
    parameter int unsigned N     = 2,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;

    // NOTE: every output and temporary gets a default before the loop so no path
    // leaves a value unassigned; otherwise synthesis infers a latch.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        cand  = '0;
        // Walk from the farthest offset down so the nearest request wins last.
        for (int i = int'(N) - 1; i >= 0; i--) begin
            cand = IDX_W'((int'(ptr_i) + i) % int'(N));
            if (req_i[cand]) begin
                gnt_o       = '0;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
                any_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous slave port among NUM_REQ requesters,
// with a lock for atomic sequences and a latency-matched read-response router.
module mem_port_arbiter
    import RS5_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_REQ-1:0]                req_en_i,
    input  logic [NUM_REQ-1:0][MEM_BE_W-1:0]  req_we_i,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]    req_addr_i,
    input  logic [NUM_REQ-1:0][MEM_DATA_W-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]                req_lock_i,
    output logic [NUM_REQ-1:0]                req_gnt_o,
    output logic [NUM_REQ-1:0]                req_rvalid_o,
    output logic [MEM_DATA_W-1:0]             req_rdata_o,
    output logic                              slv_en_o,
    output logic [MEM_BE_W-1:0]               slv_we_o,
    output logic [ADDR_W-1:0]                 slv_addr_o,
    output logic [MEM_DATA_W-1:0]             slv_data_o,
    input  logic [MEM_DATA_W-1:0]             slv_data_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] pick_req;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic               gnt_any;
    logic               granted;
    logic               sel_lock;
    logic               push_vld;

    // While locked only the owner may compete, even if the slave would otherwise idle.
    assign owner_mask = NUM_REQ'(1) << owner_q;
    assign pick_req   = (state_q == ARB_LOCKED) ? (req_en_i & owner_mask) : req_en_i;

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i (pick_req),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    assign granted   = reset_n & gnt_any;
    assign req_gnt_o = reset_n ? pick_gnt : '0;
    assign slv_en_o  = granted;

    always_comb begin
        slv_we_o   = '0;
        slv_addr_o = '0;
        slv_data_o = '0;
        sel_lock   = 1'b0;
        if (granted) begin
            slv_we_o   = req_we_i[gnt_idx];
            slv_addr_o = req_addr_i[gnt_idx];
            slv_data_o = req_data_i[gnt_idx];
            sel_lock   = req_lock_i[gnt_idx];
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        case (state_q)
            ARB_IDLE: begin
                if (granted) begin
                    rr_ptr_d = IDX_W'(rr_next(int'(gnt_idx), NUM_REQ));
                    if (sel_lock) begin
                        state_d = ARB_LOCKED;
                        owner_d = gnt_idx;
                    end
                end
            end
            ARB_LOCKED: begin
                // Release on the unlocking transfer or when the owner abandons the lock.
                if (!req_en_i[owner_q] || (granted && !sel_lock)) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = IDX_W'(rr_next(int'(owner_q), NUM_REQ));
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
        end
    end

    // Response pipeline: stage 0 is written on the grant edge, stage LATENCY-1 drives rvalid.
    logic [LATENCY-1:0]            pipe_vld_q;
    logic [LATENCY-1:0][IDX_W-1:0] pipe_id_q;
    logic [LATENCY:0]              vld_chain;
    logic [LATENCY:0][IDX_W-1:0]   id_chain;

    assign push_vld  = granted && (slv_we_o == '0);
    assign vld_chain = {pipe_vld_q, push_vld};
    assign id_chain  = {pipe_id_q, gnt_idx};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe_vld_q <= '0;
        end else begin
            pipe_vld_q <= vld_chain[LATENCY-1:0];
        end
    end

    // NOTE: the id stages are only observed when their valid bit is set, so only
    // the valid bits need a reset; the id storage stays reset-free.
    always_ff @(posedge clk) begin
        pipe_id_q <= id_chain[LATENCY-1:0];
    end

    always_comb begin
        req_rvalid_o = '0;
        if (pipe_vld_q[LATENCY-1]) begin
            req_rvalid_o[pipe_id_q[LATENCY-1]] = 1'b1;
        end
    end

    assign req_rdata_o = slv_data_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter with LATENCY=1 and one with LATENCY=3, each behind a small RAM model.
module tb_mem_port_arbiter;
    import RS5_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Instance a: LATENCY=1
    logic [1:0]        a_en, a_lock, a_gnt, a_rvalid;
    logic [1:0][3:0]   a_we;
    logic [1:0][31:0]  a_addr, a_data;
    logic [31:0]       a_rdata, a_slv_addr, a_slv_data;
    logic [31:0]       a_sd = '0;
    logic              a_slv_en;
    logic [3:0]        a_slv_we;

    // Instance b: LATENCY=3
    logic [1:0]        b_en, b_lock, b_gnt, b_rvalid;
    logic [1:0][3:0]   b_we;
    logic [1:0][31:0]  b_addr, b_data;
    logic [31:0]       b_rdata, b_slv_addr, b_slv_data;
    logic [31:0]       b_sd = '0, b_p0 = '0, b_p1 = '0;
    logic              b_slv_en;
    logic [3:0]        b_slv_we;

    mem_port_arbiter #(.NUM_REQ(2), .LATENCY(1), .ADDR_W(32)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .req_en_i(a_en), .req_we_i(a_we), .req_addr_i(a_addr), .req_data_i(a_data),
        .req_lock_i(a_lock), .req_gnt_o(a_gnt), .req_rvalid_o(a_rvalid), .req_rdata_o(a_rdata),
        .slv_en_o(a_slv_en), .slv_we_o(a_slv_we), .slv_addr_o(a_slv_addr),
        .slv_data_o(a_slv_data), .slv_data_i(a_sd)
    );

    mem_port_arbiter #(.NUM_REQ(2), .LATENCY(3), .ADDR_W(32)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_en_i(b_en), .req_we_i(b_we), .req_addr_i(b_addr), .req_data_i(b_data),
        .req_lock_i(b_lock), .req_gnt_o(b_gnt), .req_rvalid_o(b_rvalid), .req_rdata_o(b_rdata),
        .slv_en_o(b_slv_en), .slv_we_o(b_slv_we), .slv_addr_o(b_slv_addr),
        .slv_data_o(b_slv_data), .slv_data_i(b_sd)
    );

    function automatic logic [31:0] ram_word(input logic [31:0] addr);
        return (addr == 32'h0000_0100) ? 32'hDEAD_BEEF : (addr ^ 32'h5A5A_0000);
    endfunction

    function automatic logic [31:0] wdata(input logic [31:0] addr);
        return addr ^ 32'h1234_0000;
    endfunction

    always @(posedge clk) begin
        a_sd <= (a_slv_en && a_slv_we == 4'h0) ? ram_word(a_slv_addr) : 32'h0;
        b_p0 <= (b_slv_en && b_slv_we == 4'h0) ? ram_word(b_slv_addr) : 32'h0;
        b_p1 <= b_p0;
        b_sd <= b_p1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_en = '0; a_we = '0; a_addr = '0; a_data = '0; a_lock = '0;
    endtask

    task automatic clear_b();
        b_en = '0; b_we = '0; b_addr = '0; b_data = '0; b_lock = '0;
    endtask

    task automatic set_a(input bit r, input logic en, input logic [3:0] we,
                         input logic [31:0] addr, input logic lock);
        a_en[r] = en; a_we[r] = we; a_addr[r] = addr; a_data[r] = wdata(addr); a_lock[r] = lock;
    endtask

    task automatic set_b(input bit r, input logic en, input logic [3:0] we, input logic [31:0] addr);
        b_en[r] = en; b_we[r] = we; b_addr[r] = addr; b_data[r] = wdata(addr); b_lock[r] = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        clear_a();
        clear_b();
    endtask

    logic [1:0] exp_gnt [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    logic [1:0] exp_rv  [4] = '{2'b00, 2'b01, 2'b10, 2'b01};

    initial begin
        // Reset with both requesters asking: nothing may reach the slave.
        reset_n = 1'b0;
        clear_a();
        clear_b();
        a_en = 2'b11;
        b_en = 2'b11;
        cyc(); #3;
        check("rst_gnt", a_gnt, 2'b00);
        check("rst_slv_en", a_slv_en, 1'b0);
        check("rst_rvalid", a_rvalid, 2'b00);
        check("rst_ptr", dut1.rr_ptr_q, 0);
        check("rst_state", dut1.state_q, ARB_IDLE);
        cyc();
        reset_n = 1'b1;
        clear_a();
        clear_b();

        // Solo read
        cyc(); set_a(0, 1'b1, 4'h0, 32'h100, 1'b0); #3;
        check("solo_gnt", a_gnt, 2'b01);
        check("solo_slv_en", a_slv_en, 1'b1);
        check("solo_slv_addr", a_slv_addr, 32'h100);
        check("solo_slv_we", a_slv_we, 4'h0);
        cyc(); clear_a(); #3;
        check("solo_rvalid", a_rvalid, 2'b01);
        check("solo_rdata", a_rdata, 32'hDEAD_BEEF);
        check("solo_idle_gnt", a_gnt, 2'b00);
        check("solo_idle_addr", a_slv_addr, 32'h0);
        check("solo_ptr", dut1.rr_ptr_q, 1);

        // Contention: both read continuously
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc();
            set_a(0, 1'b1, 4'h0, 32'h10, 1'b0);
            set_a(1, 1'b1, 4'h0, 32'h20, 1'b0);
            #3;
            check($sformatf("cont_gnt%0d", k), a_gnt, exp_gnt[k]);
            check($sformatf("cont_rv%0d", k), a_rvalid, exp_rv[k]);
        end
        cyc(); clear_a(); #3;
        check("cont_rv4", a_rvalid, 2'b10);
        check("cont_ptr_wrap", dut1.rr_ptr_q, 0);

        // Lock: requester 1 owns the port for write/read/write while requester 0 waits
        do_reset();
        cyc(); set_a(0, 1'b1, 4'h0, 32'h300, 1'b0); #3;
        check("lock_pre_gnt", a_gnt, 2'b01);
        cyc(); set_a(1, 1'b1, 4'hF, 32'h200, 1'b1); #3;
        check("lock_w0_gnt", a_gnt, 2'b10);
        check("lock_w0_we", a_slv_we, 4'hF);
        check("lock_w0_addr", a_slv_addr, 32'h200);
        check("lock_w0_data", a_slv_data, wdata(32'h200));
        check("lock_w0_rv", a_rvalid, 2'b01);
        cyc(); set_a(1, 1'b1, 4'h0, 32'h204, 1'b1); #3;
        check("lock_r_gnt", a_gnt, 2'b10);
        check("lock_r_state", dut1.state_q, ARB_LOCKED);
        check("lock_r_rv", a_rvalid, 2'b00);
        cyc(); set_a(1, 1'b1, 4'hF, 32'h204, 1'b0); #3;
        check("lock_w1_gnt", a_gnt, 2'b10);
        check("lock_w1_rv", a_rvalid, 2'b10);
        cyc(); set_a(1, 1'b0, 4'h0, 32'h0, 1'b0); #3;
        check("lock_rel_gnt", a_gnt, 2'b01);
        check("lock_rel_state", dut1.state_q, ARB_IDLE);
        check("lock_rel_ptr", dut1.rr_ptr_q, 0);
        check("lock_rel_rv", a_rvalid, 2'b00);
        cyc(); clear_a(); #3;
        check("lock_post_rv", a_rvalid, 2'b01);

        // Abandon: owner drops its request while locked
        do_reset();
        cyc(); set_a(0, 1'b1, 4'h0, 32'h400, 1'b1); #3;
        check("abn_gnt0", a_gnt, 2'b01);
        cyc(); set_a(0, 1'b0, 4'h0, 32'h0, 1'b0); set_a(1, 1'b1, 4'h0, 32'h500, 1'b0); #3;
        check("abn_state_locked", dut1.state_q, ARB_LOCKED);
        check("abn_gnt_none", a_gnt, 2'b00);
        check("abn_slv_en", a_slv_en, 1'b0);
        cyc(); #3;
        check("abn_state_idle", dut1.state_q, ARB_IDLE);
        check("abn_ptr", dut1.rr_ptr_q, 1);
        check("abn_gnt1", a_gnt, 2'b10);
        cyc(); clear_a();

        // LATENCY=3: reads 0,1,0 back to back
        do_reset();
        cyc(); set_b(0, 1'b1, 4'h0, 32'h600); #3;
        check("l3_gnt0", b_gnt, 2'b01);
        check("l3_rv_c0", b_rvalid, 2'b00);
        cyc(); clear_b(); set_b(1, 1'b1, 4'h0, 32'h604); #3;
        check("l3_gnt1", b_gnt, 2'b10);
        check("l3_rv_c1", b_rvalid, 2'b00);
        cyc(); clear_b(); set_b(0, 1'b1, 4'h0, 32'h608); #3;
        check("l3_gnt2", b_gnt, 2'b01);
        check("l3_rv_c2", b_rvalid, 2'b00);
        cyc(); clear_b(); #3;
        check("l3_rv_c3", b_rvalid, 2'b01);
        check("l3_rdata_c3", b_rdata, ram_word(32'h600));
        cyc(); #3;
        check("l3_rv_c4", b_rvalid, 2'b10);
        check("l3_rdata_c4", b_rdata, ram_word(32'h604));
        cyc(); #3;
        check("l3_rv_c5", b_rvalid, 2'b01);
        cyc(); #3;
        check("l3_rv_c6", b_rvalid, 2'b00);

        // Reset while a read is in flight (LATENCY=3 instance)
        do_reset();
        cyc(); set_b(0, 1'b1, 4'h0, 32'h700); #3;
        check("mid_gnt", b_gnt, 2'b01);
        cyc(); reset_n = 1'b0; #3;
        check("mid_rst_gnt", b_gnt, 2'b00);
        check("mid_rst_slv_en", b_slv_en, 1'b0);
        check("mid_rst_rv", b_rvalid, 2'b00);
        for (int k = 0; k < 2; k++) begin
            cyc(); #3;
            check($sformatf("mid_rst_hold_en%0d", k), b_slv_en, 1'b0);
            check($sformatf("mid_rst_hold_rv%0d", k), b_rvalid, 2'b00);
        end
        cyc(); reset_n = 1'b1; clear_b(); #3;
        check("mid_ptr", dut3.rr_ptr_q, 0);
        check("mid_state", dut3.state_q, ARB_IDLE);
        for (int k = 0; k < 4; k++) begin
            cyc(); #3;
            check($sformatf("mid_post_rv%0d", k), b_rvalid, 2'b00);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
